// File: rtl/mdl_xxx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// mdl_xxx_fifo_pkg
// Shared constants for the AXI4-Stream elastic FIFO between the DMA/stream
// interface and the accelerator core.
//   FIFO_DATA_W    default TDATA width
//   FIFO_KEEP_W    default TKEEP width (one bit per data byte)
//   FIFO_DEPTH_DEF default number of entries (power of two, >= 2)
//   FIFO_CNT_W     width of the occupancy port seen by software/debug
// -----------------------------------------------------------------------------
package mdl_xxx_fifo_pkg;

    localparam int FIFO_DATA_W    = 64;
    localparam int FIFO_KEEP_W    = FIFO_DATA_W / 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_CNT_W     = 32;

    // Width of one stored entry: {TLAST, TKEEP, TDATA}.
    function automatic int fifo_entry_w(input int data_w);
        return data_w + (data_w / 8) + 1;
    endfunction

    // Pointer width for a power-of-two depth; at least one bit.
    function automatic int fifo_ptr_w(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mdl_xxx_fifo_ram.sv
// -----------------------------------------------------------------------------
// mdl_xxx_fifo_ram
// Storage array for the stream FIFO: one synchronous write port and one
// asynchronous read port, shaped so it maps onto distributed RAM.
// Contents are never cleared; the FIFO control logic decides what is valid.
//   clk    write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
// -----------------------------------------------------------------------------
module mdl_xxx_fifo_ram #(
    parameter int WIDTH  = 73,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mdl_xxx_fifo.sv
// -----------------------------------------------------------------------------
// mdl_xxx_fifo
// Single-clock AXI4-Stream FIFO with TKEEP/TLAST sideband, first-word
// fall-through on the read side, and an occupancy count for software/debug.
//   iSYS_CLK            clock, rising edge
//   iSYS_RST            synchronous active-high reset
//   iS_AXIS_*           slave (write) side: TVALID/TREADY/TDATA/TKEEP/TLAST
//   iM_AXIS_TREADY      master (read) side ready from the consumer
//   oM_AXIS_*           master side: TVALID and head-of-FIFO word
//   axis_rd_data_count  words stored (0..DEPTH), zero-extended
// -----------------------------------------------------------------------------
module mdl_xxx_fifo
    import mdl_xxx_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                  iSYS_CLK,
    input  logic                  iSYS_RST,
    input  logic                  iS_AXIS_TVALID,
    output logic                  oS_AXIS_TREADY,
    input  logic [DATA_W-1:0]     iS_AXIS_TDATA,
    input  logic [DATA_W/8-1:0]   iS_AXIS_TKEEP,
    input  logic                  iS_AXIS_TLAST,
    output logic                  oM_AXIS_TVALID,
    input  logic                  iM_AXIS_TREADY,
    output logic [DATA_W-1:0]     oM_AXIS_TDATA,
    output logic [DATA_W/8-1:0]   oM_AXIS_TKEEP,
    output logic                  oM_AXIS_TLAST,
    output logic [FIFO_CNT_W-1:0] axis_rd_data_count
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int ENTRY_W = fifo_entry_w(DATA_W);
    localparam int PTR_W   = fifo_ptr_w(DEPTH);
    localparam int OCC_W   = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               full;
    logic               empty;
    logic               wr_fire;
    logic               rd_fire;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign full  = (occ == OCC_FULL);
    assign empty = (occ == '0);

    // Both handshake outputs are forced low while reset is asserted so the
    // neighbours never see a stale occupancy during the reset cycle.
    assign oS_AXIS_TREADY = !full && !iSYS_RST;
    assign oM_AXIS_TVALID = !empty && !iSYS_RST;

    assign wr_fire = iS_AXIS_TVALID && oS_AXIS_TREADY;
    assign rd_fire = oM_AXIS_TVALID && iM_AXIS_TREADY;

    assign wr_entry = {iS_AXIS_TLAST, iS_AXIS_TKEEP, iS_AXIS_TDATA};

    mdl_xxx_fifo_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk    (iSYS_CLK),
        .we     (wr_fire),
        .waddr  (wr_ptr),
        .wdata  (wr_entry),
        .raddr  (rd_ptr),
        .rdata  (rd_entry)
    );

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps by itself.
    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_fire && !rd_fire) begin
                occ <= occ + OCC_ONE;
            end else if (rd_fire && !wr_fire) begin
                occ <= occ - OCC_ONE;
            end
        end
    end

    assign oM_AXIS_TDATA = rd_entry[DATA_W-1:0];
    assign oM_AXIS_TKEEP = rd_entry[DATA_W +: KEEP_W];
    assign oM_AXIS_TLAST = rd_entry[ENTRY_W-1];

    assign axis_rd_data_count = iSYS_RST ? '0
                              : {{(FIFO_CNT_W-OCC_W){1'b0}}, occ};

endmodule

// File: tb/tb_mdl_xxx_fifo.sv
module tb_mdl_xxx_fifo;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int EW    = DW + KW + 1;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [31:0]   count;

    int vectors = 0;
    int miscompares = 0;

    logic [EW-1:0] q[$];
    logic          last_wr;
    logic          last_rd;

    mdl_xxx_fifo dut (
        .iSYS_CLK           (clk),
        .iSYS_RST           (rst),
        .iS_AXIS_TVALID     (s_tvalid),
        .oS_AXIS_TREADY     (s_tready),
        .iS_AXIS_TDATA      (s_tdata),
        .iS_AXIS_TKEEP      (s_tkeep),
        .iS_AXIS_TLAST      (s_tlast),
        .oM_AXIS_TVALID     (m_tvalid),
        .iM_AXIS_TREADY     (m_tready),
        .oM_AXIS_TDATA      (m_tdata),
        .oM_AXIS_TKEEP      (m_tkeep),
        .oM_AXIS_TLAST      (m_tlast),
        .axis_rd_data_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic l, input logic mr, input logic r);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        m_tready = mr;
        rst      = r;
    endtask

    // One clock: check outputs against the queue model mid-cycle, then
    // advance the model with whatever handshakes the protocol says fire.
    task automatic cycle();
        logic exp_tready;
        logic exp_tvalid;
        int   exp_count;
        @(negedge clk);
        exp_tready = !rst && (q.size() < DEPTH);
        exp_tvalid = !rst && (q.size() != 0);
        exp_count  = rst ? 0 : q.size();
        chk("s_tready", EW'(s_tready), EW'(exp_tready));
        chk("m_tvalid", EW'(m_tvalid), EW'(exp_tvalid));
        chk("count", EW'(count), EW'(exp_count));
        if (exp_tvalid) begin
            chk("m_word", {m_tlast, m_tkeep, m_tdata}, q[0]);
        end
        last_wr = s_tvalid && exp_tready;
        last_rd = exp_tvalid && m_tready;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (last_rd) void'(q.pop_front());
            if (last_wr) q.push_back({s_tlast, s_tkeep, s_tdata});
        end
        #1;
    endtask

    initial begin
        int sent;
        int guard;
        logic [DW-1:0] rd64;
        last_wr = 1'b0;
        last_rd = 1'b0;

        // 1: reset for two cycles, then ready rises
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();

        // 2: single write with consumer ready
        drive(1'b1, 64'hDEADBEEFCAFEBABE, 8'hFF, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        chk("single_drained", EW'(count), EW'(0));

        // 3: two-word packet
        drive(1'b1, 64'hDEADBEEFCAFEBABE, 8'hFF, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle();

        // 4: fill with consumer stalled, 17th write refused, then drain
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b1, 64'(i), 8'hFF, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("full_count", EW'(count), EW'(DEPTH));
        chk("full_tready", EW'(s_tready), EW'(0));
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        repeat (DEPTH + 1) cycle();

        // 5: full with both sides active, then balanced streaming at 8
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 8'h0F, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 64'h1FF, 8'h0F, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        repeat (7) cycle();
        chk("half_count", EW'(count), EW'(8));
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h200 + 64'(i), 8'h3C, i[0], 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        repeat (10) cycle();

        // 6: mid-stream reset at count 5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h300 + 64'(i), 8'hFF, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 64'h3FF, 8'hFF, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 64'hA5, 8'h01, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();

        // 7: 40 random words with random stalls on both sides (wraps pointers)
        sent  = 0;
        guard = 0;
        rd64  = {$urandom(), $urandom()};
        drive(1'b0, rd64, 8'($urandom()), 1'($urandom()), 1'b0, 1'b0);
        while ((sent < 40 || q.size() != 0) && guard < 2000) begin
            if (sent < 40 && !s_tvalid) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
            end else if (sent >= 40) begin
                s_tvalid = 1'b0;
            end
            m_tready = ($urandom_range(0, 2) != 0);
            cycle();
            guard++;
            if (last_wr) begin
                sent++;
                rd64 = {$urandom(), $urandom()};
                s_tdata  = rd64;
                s_tkeep  = 8'($urandom());
                s_tlast  = 1'($urandom());
                s_tvalid = 1'b0;
            end
        end
        chk("random_done", EW'(guard < 2000), EW'(1));
        chk("random_sent", EW'(sent), EW'(40));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
